// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register write-port arbiter.
package reg_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int GID_W       = $clog2(NUM_REQ_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] rot;
  logic [IW:0]    sum;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    // Rotating a doubled copy puts request ptr at bit 0; scanning downward lets
    // the lowest offset (highest priority) win the last assignment.
    rot   = {req, req} >> ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        sum   = (IW + 1)'(ptr) + (IW + 1)'(k);
        if (sum >= (IW + 1)'(N)) begin
          sum = sum - (IW + 1)'(N);
        end
        idx = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter driving one write cycle into a shared register, then acking the winner.
module reg_wr_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      we_n,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gid_q, gid_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 we_n_q, we_n_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [DATA_W-1:0]    pick_data;

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    wdata_d = wdata_q;
    we_n_d  = 1'b1;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (en && pick_valid) begin
          gid_d   = pick_idx;
          wdata_d = pick_data;
          we_n_d  = 1'b0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          ack_d[i] = (gid_q == IDX_W'(i));
        end
        // Winner drops to lowest priority for the next arbitration.
        ptr_d   = (gid_q == IDX_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign we_n     = we_n_q;
  assign wr_data  = wdata_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter with a model of the target 8-bit register on we_n/wr_data.
module tb_reg_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        we_n;
  logic [7:0]  wr_data;
  logic        busy;
  logic [1:0]  grant_id;

  reg_wr_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .req_data(req_data),
    .ack     (ack),
    .we_n    (we_n),
    .wr_data (wr_data),
    .busy    (busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Target register: captures wr_data on any edge where we_n is low, unless the write is aborted.
  logic [7:0] regv = 8'h00;
  always_ff @(posedge clk) begin
    if (!we_n && !rst) regv <= wr_data;
  end

  typedef struct {
    int         gid;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          gid;
    int          lat;
  } vec_t;

  exp_t exp_q[$];
  vec_t vt[10];

  int         checks = 0;
  int         errors = 0;
  logic       ack_pend = 1'b0;
  int         ack_gid = 0;
  logic [7:0] ack_data = '0;
  logic       ack_seen = 1'b0;
  logic       we_now = 1'b0;
  int         hold_gid = 0;
  logic [7:0] hold_data = '0;
  logic [7:0] reg_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int gid, input logic [31:0] data);
    exp_t e;
    e.gid  = gid;
    e.data = data[gid*8 +: 8];
    exp_q.push_back(e);
  endtask

  // One clock: sample at the falling edge and check every output against the scoreboard.
  task automatic cyc();
    logic rst_e;
    logic had_pend;
    exp_t e;
    rst_e    = rst;
    had_pend = ack_pend;
    @(posedge clk);
    @(negedge clk);
    ack_seen = 1'b0;
    ack_pend = 1'b0;
    we_now   = !we_n;
    if (rst_e) begin
      hold_gid  = 0;
      hold_data = '0;
      chk("we_n_reset", {31'd0, we_n}, 32'd1);
    end
    if (had_pend && !rst_e) begin
      chk("ack_onehot", {28'd0, ack}, 32'd1 << ack_gid);
      reg_exp  = ack_data;
      ack_seen = 1'b1;
    end else begin
      chk("ack_low", {28'd0, ack}, 32'd0);
    end
    chk("register", {24'd0, regv}, {24'd0, reg_exp});
    if (!we_n && !rst_e) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data %0h gid %0d expected no write at %0t",
                 wr_data, grant_id, $time);
      end else begin
        e         = exp_q.pop_front();
        hold_gid  = e.gid;
        hold_data = e.data;
        ack_pend  = 1'b1;
        ack_gid   = e.gid;
        ack_data  = e.data;
      end
    end
    chk("grant_id", {30'd0, grant_id}, hold_gid);
    chk("wr_data", {24'd0, wr_data}, {24'd0, hold_data});
    chk("busy", {31'd0, busy}, {31'd0, (!we_n) || (had_pend && !rst_e)});
  endtask

  // Drive one request pattern, expect the given winner after lat cycles, then its ack.
  task automatic run_vec(input logic [3:0] r, input logic [31:0] d, input int gid, input int lat);
    int   n;
    logic got;
    en       = 1'b1;
    req      = r;
    req_data = d;
    push(gid, d);
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      cyc();
      n++;
      if (we_now) begin
        got      = 1'b1;
        req_data = ~req_data;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: got no we_n low in 8 cycles expected gid %0d", gid);
      exp_q.delete();
    end else begin
      chk("latency", n, lat);
      cyc();
      chk("ack_seen", {31'd0, ack_seen}, 32'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    vt[0] = '{4'b1111, 32'h13121110, 0, 1};
    vt[1] = '{4'b1110, 32'h13121110, 1, 2};
    vt[2] = '{4'b1100, 32'h13121110, 2, 2};
    vt[3] = '{4'b1000, 32'h13121110, 3, 2};
    vt[4] = '{4'b1001, 32'h23222120, 0, 2};
    vt[5] = '{4'b1000, 32'h23222120, 3, 2};
    vt[6] = '{4'b0110, 32'h33323130, 1, 2};
    vt[7] = '{4'b0011, 32'h43424140, 0, 2};
    vt[8] = '{4'b0101, 32'h53525150, 2, 2};
    vt[9] = '{4'b0101, 32'h53525150, 0, 2};

    // Reset and idle outputs
    do_reset();
    for (int i = 0; i < 3; i++) cyc();

    // Single requester
    run_vec(4'b0001, 32'h000000A5, 0, 1);
    req = '0;
    cyc();
    cyc();

    // Round-robin order, wrap and mixed patterns from a fresh pointer
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_vec(vt[i].req, vt[i].data, vt[i].gid, vt[i].lat);
    end
    req = '0;
    cyc();
    cyc();

    // Enable gating: nothing while en=0, then grant, then en dropped mid-write
    en       = 1'b0;
    req      = 4'b0010;
    req_data = 32'h00005500;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("en_off_no_write", {31'd0, we_now}, 32'd0);
    end
    en = 1'b1;
    push(1, req_data);
    cyc();
    chk("en_on_write", {31'd0, we_now}, 32'd1);
    en = 1'b0;
    cyc();
    chk("en_drop_ack", {31'd0, ack_seen}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("en_hold_idle", {31'd0, we_now}, 32'd0);
    end
    req = '0;
    cyc();

    // Reset during WRITE aborts without ack; pointer returns to 0
    en       = 1'b1;
    req      = 4'b0100;
    req_data = 32'h003C7700;
    push(2, req_data);
    cyc();
    chk("abort_write_seen", {31'd0, we_now}, 32'd1);
    rst = 1'b1;
    req = 4'b0110;
    cyc();
    rst = 1'b0;
    run_vec(4'b0110, 32'h003C7700, 1, 1);
    run_vec(4'b0100, 32'h003C7700, 2, 2);
    req = '0;
    for (int i = 0; i < 3; i++) cyc();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
